rr_mem_scheduler: RTL and testbench
===================================

RR_MEM_SCHEDULER -- requirements
Module: rr_mem_scheduler

Interface
REQ-001 SHALL have parameter N_CPU, default 3, number of requesting CPU cores.
REQ-002 SHALL have parameter MAX_TENURE, default 16, maximum consecutive granted cycles per ownership.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port req_arb  input  [N_CPU] x 1  per-CPU access request; held high for the whole access.
REQ-006 SHALL have port address_in  input  [N_CPU] x 12  per-CPU shared-memory address.
REQ-007 SHALL have port data_in  input  [N_CPU] x 8  per-CPU write data.
REQ-008 SHALL have port wr_en  input  [N_CPU] x 1  per-CPU write strobe; 0 means read.
REQ-009 SHALL have port gnt_arb  output  [N_CPU] x 1  registered grant; at most one bit high.
REQ-010 SHALL have port owner_id  output  2  index of current owner; valid only while busy is high.
REQ-011 SHALL have port busy  output  1  high while a grant is held.
REQ-012 SHALL have port mem_en, mem_we, mem_addr[11:0], mem_wdata[7:0]  output  shared-memory command muxed from the owner.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when ownership is force-revoked.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, TURN.
REQ-015 IDLE: if any req_arb is high at an edge, SHALL select a winner, go to BUSY, and assert gnt_arb[winner] after that edge (1-cycle request-to-grant latency).
REQ-016 Winner SHALL be chosen round-robin: search from (last_owner+1) mod N_CPU upward, wrapping; first requester found wins.
REQ-017 BUSY: mem_en SHALL be high and mem_addr/mem_wdata/mem_we SHALL equal the owner's inputs (combinational mux on the registered owner); all three SHALL be zero while mem_en is low.
REQ-018 BUSY: a tenure counter SHALL count granted cycles starting at 0 on the first grant cycle.
REQ-019 BUSY: if req_arb[owner] is low at an edge, SHALL drop the grant, record last_owner, and go to TURN; mem_en SHALL be low in that cycle.
REQ-020 BUSY: if the counter reaches MAX_TENURE-1 with req_arb[owner] still high, SHALL drop the grant at the next edge, pulse timeout for one cycle, record last_owner, and go to TURN.
REQ-021 If the owner drops its request in the same cycle as tenure expiry, SHALL treat it as a normal release with no timeout pulse.
REQ-022 TURN SHALL last exactly one cycle with all grants low, then go to IDLE, giving a 2-cycle gap between consecutive grants.
REQ-023 Requests from non-owners during BUSY or TURN SHALL be held pending and arbitrated in IDLE; a revoked owner that keeps requesting SHALL get lowest priority next round.
REQ-024 Requests arriving in IDLE with none active SHALL leave the FSM in IDLE with all outputs at reset values.

Reset
REQ-025 When rst=0 at an edge: state=IDLE, gnt_arb=0, busy=0, owner_id=0, timeout=0, counter=0, last_owner=N_CPU-1 (CPU0 has first priority).
REQ-026 Reset asserted mid-BUSY SHALL drop the grant at that edge; no timeout pulse; the partial access is abandoned.

Structure
REQ-027 N_CPU, MAX_TENURE defaults and the FSM state enum (sched_state_t) SHALL live in the shared package pkg alongside opcode.
REQ-028 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: request vector, last_owner; outputs: winner index, any_req).
REQ-029 Block SHALL fit between the CPUs' req_arb/gnt_arb and the shared memory, as a drop-in replacement for the current arbiter instance.

Verification
REQ-030 Reset then req_arb=3'b001 -> gnt_arb=3'b001 one cycle later; mem_addr equals address_in[0] (e.g. 12'h0A5).
REQ-031 req_arb=3'b111 held, each owner releasing after 3 cycles -> grant order 0,1,2,0 with exactly 2 grant-free cycles between grants.
REQ-032 req_arb[1] held 20 cycles, MAX_TENURE=16 -> grant for 16 cycles, timeout pulses once, 2-cycle gap, CPU1 re-granted if no other request.
REQ-033 Owner 2 drops req_arb on its 16th cycle while CPU0 requests -> no timeout pulse; CPU0 granted next.
REQ-034 rst=0 during BUSY with wr_en=1, data_in=8'h3C -> next edge gnt_arb=0, mem_en=0, mem_we=0, busy=0.
REQ-035 Bench SHALL check every cycle that gnt_arb is one-hot-or-zero and that mem_en implies busy.

Source files
------------

// File: rtl/rr_mem_scheduler_pkg.sv
// Shared definitions for the round-robin memory scheduler: default sizing,
// bus widths, FSM state encoding and the memory opcode.
package rr_mem_scheduler_pkg;

  localparam int DEF_N_CPU      = 3;
  localparam int DEF_MAX_TENURE = 16;
  localparam int ADDR_W         = 12;
  localparam int DATA_W         = 8;
  localparam int IDX_W          = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } sched_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } opcode_t;

endpackage

// File: rtl/rr_mem_scheduler_rr_pick.sv
// Combinational round-robin search: first requester after the last owner,
// wrapping around, wins.
module rr_pick
  import rr_mem_scheduler_pkg::*;
#(
  parameter int N_CPU = DEF_N_CPU
)
(
  input  logic [N_CPU-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_req
);

  int w_idx;

  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = 0;
    for (int i = 1; i <= N_CPU; i++) begin
      w_idx = (int'(i_last_owner) + i) % N_CPU;
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req = 1'b1;
        o_winner  = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/rr_mem_scheduler.sv
// Round-robin arbiter in front of a shared memory: grants one CPU at a time,
// bounds each tenure, and muxes the owner's command onto the memory port.
module rr_mem_scheduler
  import rr_mem_scheduler_pkg::*;
#(
  parameter int N_CPU      = DEF_N_CPU,
  parameter int MAX_TENURE = DEF_MAX_TENURE
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CPU-1:0]              req_arb,
  input  logic [N_CPU-1:0][ADDR_W-1:0]  address_in,
  input  logic [N_CPU-1:0][DATA_W-1:0]  data_in,
  input  logic [N_CPU-1:0]              wr_en,
  output logic [N_CPU-1:0]              gnt_arb,
  output logic [IDX_W-1:0]              owner_id,
  output logic                          busy,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          timeout
);

  localparam int CNT_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;

  sched_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_last_owner, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N_CPU-1:0] r_gnt, w_gnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [IDX_W-1:0] w_winner;
  logic             w_any_req;
  opcode_t          w_op;

  rr_pick #(.N_CPU(N_CPU)) u_rr_pick (
    .i_req        (req_arb),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(N_CPU - 1);
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // A release in the expiry cycle wins over revocation, so no timeout then.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last_owner;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_winner;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = N_CPU'(1) << w_winner;
        end
      end
      BUSY: begin
        if (!req_arb[r_owner]) begin
          w_state_nxt = TURN;
          w_last_nxt  = r_owner;
          w_gnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(MAX_TENURE - 1)) begin
          w_state_nxt   = TURN;
          w_last_nxt    = r_owner;
          w_gnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      TURN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_op = opcode_t'(wr_en[r_owner]);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == BUSY && req_arb[r_owner]) begin
      mem_en    = 1'b1;
      mem_we    = (w_op == OP_WRITE);
      mem_addr  = address_in[r_owner];
      mem_wdata = data_in[r_owner];
    end
  end

  assign gnt_arb  = r_gnt;
  assign owner_id = r_owner;
  assign busy     = (r_state == BUSY);
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_rr_mem_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_rr_mem_scheduler;

  localparam int N_CPU      = 3;
  localparam int MAX_TENURE = 16;

  logic                   clk = 1'b0;
  logic                   rstN = 1'b0;
  logic [N_CPU-1:0]       reqArb = '0;
  logic [N_CPU-1:0][11:0] addressIn = '0;
  logic [N_CPU-1:0][7:0]  dataIn = '0;
  logic [N_CPU-1:0]       wrEn = '0;
  logic [N_CPU-1:0]       gntArb;
  logic [1:0]             ownerId;
  logic                   busy, memEn, memWe, timeout;
  logic [11:0]            memAddr;
  logic [7:0]             memWdata;

  int nChecks = 0;
  int nPass = 0;

  int mValid = 0;
  int mBusy = 0, mOwner = 0, mLast = N_CPU - 1, mTenure = 0, mTurn = 0, mTimeout = 0;
  int mCand = 0;

  rr_mem_scheduler #(.N_CPU(N_CPU), .MAX_TENURE(MAX_TENURE)) dut (
    .clk        (clk),
    .rst        (rstN),
    .req_arb    (reqArb),
    .address_in (addressIn),
    .data_in    (dataIn),
    .wr_en      (wrEn),
    .gnt_arb    (gntArb),
    .owner_id   (ownerId),
    .busy       (busy),
    .mem_en     (memEn),
    .mem_we     (memWe),
    .mem_addr   (memAddr),
    .mem_wdata  (memWdata),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_CPU-1:0] req, input logic [N_CPU-1:0] wr);
    reqArb = req;
    wrEn   = wr;
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    applyStimulus('0, '0);
    tick();
    tick();
    checkOutput("reset_gnt", gntArb, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_owner", ownerId, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkOutput("reset_mem_en", memEn, 0);
    rstN = 1'b1;
  endtask

  // Behavioural model: ownership, tenure and the two-cycle hand-over gap.
  always @(posedge clk) begin
    if (!rstN) begin
      mValid = 1; mBusy = 0; mOwner = 0; mLast = N_CPU - 1;
      mTenure = 0; mTurn = 0; mTimeout = 0;
    end else if (mValid != 0) begin
      mTimeout = 0;
      if (mBusy != 0) begin
        if (!reqArb[mOwner] || mTenure == MAX_TENURE - 1) begin
          mTimeout = reqArb[mOwner] ? 1 : 0;
          mBusy = 0; mLast = mOwner; mTurn = 1;
        end else begin
          mTenure++;
        end
      end else if (mTurn != 0) begin
        mTurn = 0;
      end else begin
        for (int off = 1; off <= N_CPU; off++) begin
          mCand = (mLast + off) % N_CPU;
          if (mBusy == 0 && reqArb[mCand]) begin
            mBusy = 1; mOwner = mCand; mTenure = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mValid != 0) begin
      automatic bit expEn = (mBusy != 0) && reqArb[mOwner];
      checkOutput("gnt_arb", gntArb, (mBusy != 0) ? (32'd1 << mOwner) : 32'd0);
      checkOutput("busy", busy, mBusy);
      if (mBusy != 0) checkOutput("owner_id", ownerId, mOwner);
      checkOutput("timeout", timeout, mTimeout);
      checkOutput("mem_en", memEn, expEn);
      checkOutput("mem_we", memWe, expEn ? wrEn[mOwner] : 1'b0);
      checkOutput("mem_addr", memAddr, expEn ? addressIn[mOwner] : 12'h0);
      checkOutput("mem_wdata", memWdata, expEn ? dataIn[mOwner] : 8'h0);
      checkOutput("gnt_onehot0", $onehot0(gntArb), 1);
      checkOutput("mem_en_implies_busy", (!memEn || busy), 1);
    end
  end

  initial begin
    int order[4];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;

    // Single request: one-cycle latency and address mux.
    resetDut();
    addressIn[0] = 12'h0A5;
    applyStimulus(3'b001, 3'b000);
    #1;
    checkOutput("latency_no_early_gnt", gntArb, 3'b000);
    tick();
    checkOutput("single_gnt", gntArb, 3'b001);
    checkOutput("single_addr", memAddr, 12'h0A5);
    checkOutput("single_mem_en", memEn, 1);
    applyStimulus(3'b000, 3'b000);
    #1;
    checkOutput("release_mem_en_low", memEn, 0);
    tick();
    checkOutput("release_gnt", gntArb, 3'b000);
    tick();

    // All requesting, each owner releasing after three grant cycles.
    resetDut();
    applyStimulus(3'b111, 3'b000);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("rr_order", gntArb, 32'd1 << order[k]);
      tick();
      tick();
      checkOutput("rr_hold", gntArb, 32'd1 << order[k]);
      reqArb[order[k]] = 1'b0;
      tick();
      checkOutput("rr_gap1", gntArb, 3'b000);
      reqArb[order[k]] = 1'b1;
      tick();
      checkOutput("rr_gap2", gntArb, 3'b000);
      tick();
    end

    // Tenure expiry with a lone persistent requester.
    resetDut();
    applyStimulus(3'b010, 3'b000);
    tick();
    checkOutput("tenure_first", gntArb, 3'b010);
    repeat (15) tick();
    checkOutput("tenure_16th", gntArb, 3'b010);
    checkOutput("tenure_no_early_timeout", timeout, 0);
    tick();
    checkOutput("revoke_gnt", gntArb, 3'b000);
    checkOutput("revoke_timeout", timeout, 1);
    tick();
    checkOutput("revoke_timeout_pulse", timeout, 0);
    checkOutput("revoke_gap", gntArb, 3'b000);
    tick();
    checkOutput("regrant_cpu1", gntArb, 3'b010);
    applyStimulus(3'b000, 3'b000);
    repeat (3) tick();

    // Release coinciding with tenure expiry is a normal release.
    resetDut();
    applyStimulus(3'b100, 3'b000);
    tick();
    checkOutput("owner2_gnt", gntArb, 3'b100);
    applyStimulus(3'b101, 3'b000);
    repeat (15) tick();
    applyStimulus(3'b001, 3'b000);
    tick();
    checkOutput("expiry_release_timeout", timeout, 0);
    checkOutput("expiry_release_gnt", gntArb, 3'b000);
    tick();
    tick();
    checkOutput("cpu0_after_owner2", gntArb, 3'b001);
    applyStimulus(3'b000, 3'b000);
    repeat (3) tick();

    // Reset during a write access.
    resetDut();
    dataIn[0] = 8'h3C;
    addressIn[0] = 12'h123;
    applyStimulus(3'b001, 3'b001);
    tick();
    tick();
    checkOutput("write_we", memWe, 1);
    checkOutput("write_data", memWdata, 8'h3C);
    rstN = 1'b0;
    tick();
    checkOutput("midreset_gnt", gntArb, 3'b000);
    checkOutput("midreset_mem_en", memEn, 0);
    checkOutput("midreset_mem_we", memWe, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_timeout", timeout, 0);
    rstN = 1'b1;
    applyStimulus(3'b000, 3'b000);
    tick();

    // Randomized traffic; long holds exercise revocation.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N_CPU; c++) begin
        if (reqArb[c]) begin
          if ($urandom_range(0, 14) == 0) reqArb[c] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          reqArb[c] = 1'b1;
        end
        addressIn[c] = 12'($urandom);
        dataIn[c]    = 8'($urandom);
        wrEn[c]      = 1'($urandom);
      end
      rstN = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
